// File: rtl/icache_dm.sv
// Direct-mapped instruction cache with whole-line refill over a req/ack word bus.
// One-cycle registered hit latency; stalls the fetch stream while a line is refilled.
module icache_dm #(
    parameter int          LINES = 16,
    parameter int          WORDS = 4,
    parameter logic [31:0] NOP   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_addr,
    input  logic        flush,
    output logic [31:0] ins,
    output logic        ins_valid,
    output logic        stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);
    localparam int OW = $clog2(WORDS);
    localparam int IW = $clog2(LINES);
    localparam int TW = 32 - OW - IW;

    typedef enum logic [1:0] {IDLE, REFILL, RESP} state_t;

    state_t             state_q, state_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic [31:0]        ins_q, ins_d;
    logic               ins_valid_q, ins_valid_d;
    logic               stall_q, stall_d;
    logic [31:0]        miss_addr_q, miss_addr_d;
    logic [OW-1:0]      cnt_q, cnt_d;
    logic               fflag_q, fflag_d;
    logic               data_we, tag_we;

    logic [TW-1:0]      tag_mem  [LINES];
    logic [31:0]        data_mem [LINES*WORDS];

    logic [OW-1:0]      off, miss_off;
    logic [IW-1:0]      idx, miss_idx;
    logic [TW-1:0]      tag, miss_tag;
    logic               hit;

    assign off      = i_addr[OW-1:0];
    assign idx      = i_addr[OW +: IW];
    assign tag      = i_addr[31 -: TW];
    assign miss_off = miss_addr_q[OW-1:0];
    assign miss_idx = miss_addr_q[OW +: IW];
    assign miss_tag = miss_addr_q[31 -: TW];

    // A flush in the lookup cycle forces a miss.
    assign hit = valid_q[idx] && (tag_mem[idx] == tag) && !flush;

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        ins_d       = ins_q;
        ins_valid_d = ins_valid_q;
        stall_d     = stall_q;
        miss_addr_d = miss_addr_q;
        cnt_d       = cnt_q;
        fflag_d     = fflag_q;
        data_we     = 1'b0;
        tag_we      = 1'b0;
        if (flush) valid_d = '0;
        unique case (state_q)
            IDLE: begin
                fflag_d = 1'b0;
                if (hit) begin
                    ins_d       = data_mem[{idx, off}];
                    ins_valid_d = 1'b1;
                end else begin
                    miss_addr_d = i_addr;
                    ins_d       = NOP;
                    ins_valid_d = 1'b0;
                    stall_d     = 1'b1;
                    cnt_d       = '0;
                    state_d     = REFILL;
                end
            end
            REFILL: begin
                if (flush) fflag_d = 1'b1;
                if (mem_ack) begin
                    data_we = 1'b1;
                    cnt_d   = cnt_q + OW'(1);
                    if (cnt_q == OW'(WORDS - 1)) begin
                        tag_we  = 1'b1;
                        if (!(fflag_q || flush)) valid_d[miss_idx] = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                ins_d       = data_mem[{miss_idx, miss_off}];
                ins_valid_d = 1'b1;
                stall_d     = 1'b0;
                fflag_d     = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            ins_q       <= NOP;
            ins_valid_q <= 1'b0;
            stall_q     <= 1'b0;
            miss_addr_q <= '0;
            cnt_q       <= '0;
            fflag_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            ins_q       <= ins_d;
            ins_valid_q <= ins_valid_d;
            stall_q     <= stall_d;
            miss_addr_q <= miss_addr_d;
            cnt_q       <= cnt_d;
            fflag_q     <= fflag_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && data_we) data_mem[{miss_idx, cnt_q}] <= mem_rdata;
        if (rst_n && tag_we)  tag_mem[miss_idx] <= miss_tag;
    end

    assign ins       = ins_q;
    assign ins_valid = ins_valid_q;
    assign stall     = stall_q;
    assign mem_req   = (state_q == REFILL);
    assign mem_addr  = mem_req ? {miss_addr_q[31:OW], cnt_q} : 32'h0;

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
Direct-mapped instruction cache. It is the responder on the fetch unit's instruction-address interface. It takes a word address each cycle and returns the 32-bit instruction with one-cycle registered latency on a hit. On a miss it raises stall, refills the whole line from the instruction memory over a req/ack word bus, then returns the missed instruction and resumes.

Parameters:
LINES, 16, number of cache lines (power of 2, ≥2)
WORDS, 4, 32-bit words per line (power of 2, ≥2)
NOP, 32'h00000013, instruction driven while no valid instruction is available (addi x0,x0,0)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk
i_addr  input  32  word address from fetch; offset = low log2(WORDS) bits, index = next log2(LINES) bits, tag = remaining upper bits
flush  input  1  invalidate all lines
ins  output  32  registered instruction
ins_valid  output  1  ins holds the instruction for the previously sampled i_addr
stall  output  1  cache is refilling; i_addr is ignored while high
mem_req  output  1  word read request to instruction memory
mem_addr  output  32  word address of the request
mem_rdata  input  32  read data, valid in the cycle mem_ack=1
mem_ack  input  1  request accepted and data present this cycle

Behaviour:
- Reset (rst_n=0 at an edge): all valid bits cleared, state=IDLE, ins=NOP, ins_valid=0, stall=0, mem_req=0, mem_addr=0, word counter=0. Reset mid-refill aborts immediately. The partially written line stays invalid. mem_req drops on the next cycle.
- States: IDLE (lookup), REFILL, RESP.
- IDLE lookup:
  - Tag/valid/data read is combinational on i_addr; the result is registered at the edge.
  - Hit: ins<=data[index][offset], ins_valid<=1. Back-to-back hits run at 1 per cycle.
  - Miss: latch miss_addr<=i_addr, ins<=NOP, ins_valid<=0, stall<=1, cnt<=0, state<=REFILL.
- REFILL:
  - mem_req=1 and mem_addr={miss_tag,miss_index,cnt} every cycle.
  - mem_addr is held stable until mem_ack=1. On ack, write mem_rdata into data[miss_index][cnt] and increment cnt.
  - Words are fetched in ascending order from offset 0 (no critical-word-first).
  - On the ack for cnt=WORDS-1: write the tag, set valid (unless the flush flag is set), and go to RESP. mem_req is 0 in RESP.
- RESP: ins<=data[miss_index][miss_offset], ins_valid<=1, stall<=0, state<=IDLE. The ins update occurs on the edge leaving RESP.
- Latency: with mem_ack tied high, a miss sampled at edge k gives ins valid and stall low after edge k+WORDS+1. This is a penalty of WORDS+1 cycles (5 at default). Each wait state (ack low) adds one cycle.
- Refill sequencing: the first i_addr sampled after stall falls is the next lookup. The fetch unit re-presents the stalled stream; the cache does not buffer i_addr.
- flush:
  - In IDLE: all valid bits are cleared at the edge. A lookup in the same cycle is a miss.
  - In REFILL: the refill runs to completion so no bus transaction is orphaned. A sticky flag suppresses setting valid, but the missed instruction is still returned in RESP. The flag clears on entering IDLE.
  - Flush and rst_n=0 together: reset wins.
- Replacement: a conflict miss overwrites the line at that index unconditionally.
- Tag compare uses the full upper field. Addresses wrap modulo 2^32 with no special casing at 32'hFFFFFFFF.
- Outputs are driven only from registers, except mem_addr/mem_req, which are registered from state and cnt.

Test Plan:
- Cold miss: reset, i_addr=0x10, memory returns 0xA0+word index, mem_ack always 1. Required: stall=1 for 5 cycles; mem_addr 0x10,0x11,0x12,0x13; then ins=0xA0, ins_valid=1.
- Hit stream: after the cold miss, present 0x11,0x12,0x13 on consecutive cycles. Required: ins=0xA1,0xA2,0xA3 one cycle each, stall=0, mem_req=0 throughout.
- Conflict: present 0x10+4*LINES (0x50). Required: refill of 0x50..0x53. A later present of 0x10 misses again and refetches.
- Wait states: mem_ack high only every 3rd cycle during a refill. Required: mem_addr is held across un-acked cycles; stall lasts 3*4+1=13 cycles; returned data is correct.
- Flush mid-refill: assert flush for one cycle during the 2nd word. Required: the refill completes, the missed ins is returned, and an immediate re-access to the same line misses.
- Reset mid-refill: rst_n=0 for one edge after 2 words. Required: ins=NOP, ins_valid=0, stall=0, mem_req=0 next cycle, and the line misses on re-access.
